// File: rtl/core_pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Holds the register-index width, MDU latency and FSM state encoding.
package core_pipe_ctrl_pkg;

  localparam int CPU_RFIDX_WIDTH = 5;
  localparam int CPU_MDU_CYCLES  = 8;

  typedef enum logic [1:0] {
    CPU_PCTL_RUN   = 2'd0,
    CPU_PCTL_MDU   = 2'd1,
    CPU_PCTL_FLUSH = 2'd2
  } pctl_state_e;

endpackage

// File: rtl/core_hazard_det.sv
// Combinational load-use hazard compare between ID sources and EX load rd.
// Ports: ID valid/enables/indices, EX valid/load/rd in; hazard_o out.
module core_hazard_det
  import core_pipe_ctrl_pkg::*;
#(
  parameter int RFIDX_W = CPU_RFIDX_WIDTH
) (
  input  logic               id_valid_i,
  input  logic               id_rs1_en_i,
  input  logic               id_rs2_en_i,
  input  logic [RFIDX_W-1:0] id_rs1_idx_i,
  input  logic [RFIDX_W-1:0] id_rs2_idx_i,
  input  logic               ex_valid_i,
  input  logic               ex_load_i,
  input  logic [RFIDX_W-1:0] ex_rd_idx_i,
  output logic               hazard_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_en_i & (id_rs1_idx_i == ex_rd_idx_i);
  assign rs2_hit = id_rs2_en_i & (id_rs2_idx_i == ex_rd_idx_i);

  // x0 is never written, so a load to x0 cannot create a dependency.
  assign hazard_o = id_valid_i & ex_valid_i & ex_load_i
                  & (ex_rd_idx_i != '0)
                  & (rs1_hit | rs2_hit);

endmodule

// File: rtl/core_pipe_ctrl.sv
// IF/ID/EX sequencing: load-use stall, MDU hold, redirect flush, stall count.
// Ports: ID/EX status and redirect in; hold/flush/bubble, busy, count out.
module core_pipe_ctrl
  import core_pipe_ctrl_pkg::*;
#(
  parameter int RFIDX_W    = CPU_RFIDX_WIDTH,
  parameter int MDU_CYCLES = CPU_MDU_CYCLES,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid_i,
  input  logic               id_rs1_en_i,
  input  logic               id_rs2_en_i,
  input  logic [RFIDX_W-1:0] id_rs1_idx_i,
  input  logic [RFIDX_W-1:0] id_rs2_idx_i,
  input  logic               id_mdu_i,
  input  logic               ex_valid_i,
  input  logic               ex_load_i,
  input  logic [RFIDX_W-1:0] ex_rd_idx_i,
  input  logic               ex_redirect_i,
  output logic               pc_hold_o,
  output logic               ifid_hold_o,
  output logic               ifid_flush_o,
  output logic               idex_bubble_o,
  output logic               ex_hold_o,
  output logic               mdu_busy_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  localparam int MCW = $clog2(MDU_CYCLES);
  localparam logic [MCW-1:0] MDU_INIT = MCW'(MDU_CYCLES - 2);

  pctl_state_e      state_q;
  logic [MCW-1:0]   mcnt_q;
  logic             busy_q;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] stall_d;
  logic             hazard;
  logic             mdu_issue;

  core_hazard_det #(
    .RFIDX_W (RFIDX_W)
  ) u_haz (
    .id_valid_i   (id_valid_i),
    .id_rs1_en_i  (id_rs1_en_i),
    .id_rs2_en_i  (id_rs2_en_i),
    .id_rs1_idx_i (id_rs1_idx_i),
    .id_rs2_idx_i (id_rs2_idx_i),
    .ex_valid_i   (ex_valid_i),
    .ex_load_i    (ex_load_i),
    .ex_rd_idx_i  (ex_rd_idx_i),
    .hazard_o     (hazard)
  );

  assign mdu_issue = ~ex_redirect_i & ~hazard & id_valid_i & id_mdu_i;

  always_comb begin
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    ex_hold_o     = 1'b0;
    unique case (state_q)
      CPU_PCTL_RUN: begin
        if (ex_redirect_i) begin
          ifid_flush_o  = 1'b1;
          idex_bubble_o = 1'b1;
        end else if (hazard) begin
          pc_hold_o     = 1'b1;
          ifid_hold_o   = 1'b1;
          idex_bubble_o = 1'b1;
        end
      end
      CPU_PCTL_MDU: begin
        pc_hold_o   = 1'b1;
        ifid_hold_o = 1'b1;
        ex_hold_o   = 1'b1;
      end
      CPU_PCTL_FLUSH: begin
        ifid_flush_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Saturate rather than wrap so a long run never reads as few stalls.
  always_comb begin
    stall_d = stall_q;
    if (pc_hold_o && !(&stall_q)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CPU_PCTL_RUN;
      mcnt_q  <= '0;
      busy_q  <= 1'b0;
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
      unique case (state_q)
        CPU_PCTL_RUN: begin
          if (ex_redirect_i) begin
            state_q <= CPU_PCTL_FLUSH;
          end else if (mdu_issue) begin
            state_q <= CPU_PCTL_MDU;
            mcnt_q  <= MDU_INIT;
            busy_q  <= 1'b1;
          end
        end
        CPU_PCTL_MDU: begin
          if (mcnt_q == '0) begin
            state_q <= CPU_PCTL_RUN;
            busy_q  <= 1'b0;
          end else begin
            mcnt_q <= mcnt_q - MCW'(1);
          end
        end
        CPU_PCTL_FLUSH: begin
          if (!ex_redirect_i) begin
            state_q <= CPU_PCTL_RUN;
          end
        end
        default: begin
          state_q <= CPU_PCTL_RUN;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu_busy_o  = busy_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Scoreboard bench for core_pipe_ctrl: directed plan items plus random traffic.
// Expected outputs come from a cycle-timeline model of the control rules.
module tb_core_pipe_ctrl;

  localparam int MDU = 8;

  typedef struct packed {
    logic       idv;
    logic       r1e;
    logic       r2e;
    logic [4:0] r1;
    logic [4:0] r2;
    logic       mdu;
    logic       exv;
    logic       exl;
    logic [4:0] rd;
    logic       redir;
  } stim_t;

  typedef struct packed {
    logic [5:0]  flags;
    logic [31:0] s32;
    logic [3:0]  s4;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_rs1_en, id_rs2_en, id_mdu;
  logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd_idx;
  logic ex_valid, ex_load, ex_redirect;

  logic pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold, mdu_busy;
  logic [31:0] stall_cnt;
  logic a_pc, a_ifh, a_ifl, a_bub, a_exh, a_busy;
  logic [3:0] stall4;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  int cyc = 0;
  int mdu_end = -1;
  int flush_end = -1;
  longint scnt = 0;

  always #5 clk = ~clk;

  core_pipe_ctrl #(.RFIDX_W(5), .MDU_CYCLES(MDU), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_rs1_en_i(id_rs1_en),
    .id_rs2_en_i(id_rs2_en), .id_rs1_idx_i(id_rs1_idx),
    .id_rs2_idx_i(id_rs2_idx), .id_mdu_i(id_mdu),
    .ex_valid_i(ex_valid), .ex_load_i(ex_load),
    .ex_rd_idx_i(ex_rd_idx), .ex_redirect_i(ex_redirect),
    .pc_hold_o(pc_hold), .ifid_hold_o(ifid_hold),
    .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble),
    .ex_hold_o(ex_hold), .mdu_busy_o(mdu_busy),
    .stall_cnt_o(stall_cnt)
  );

  core_pipe_ctrl #(.RFIDX_W(5), .MDU_CYCLES(MDU), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid), .id_rs1_en_i(id_rs1_en),
    .id_rs2_en_i(id_rs2_en), .id_rs1_idx_i(id_rs1_idx),
    .id_rs2_idx_i(id_rs2_idx), .id_mdu_i(id_mdu),
    .ex_valid_i(ex_valid), .ex_load_i(ex_load),
    .ex_rd_idx_i(ex_rd_idx), .ex_redirect_i(ex_redirect),
    .pc_hold_o(a_pc), .ifid_hold_o(a_ifh),
    .ifid_flush_o(a_ifl), .idex_bubble_o(a_bub),
    .ex_hold_o(a_exh), .mdu_busy_o(a_busy),
    .stall_cnt_o(stall4)
  );

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.idv   = 1'($urandom_range(0, 1));
    s.r1e   = 1'($urandom_range(0, 1));
    s.r2e   = 1'($urandom_range(0, 1));
    s.r1    = 5'($urandom_range(0, 3));
    s.r2    = 5'($urandom_range(0, 3));
    s.mdu   = ($urandom_range(0, 5) == 0);
    s.exv   = 1'($urandom_range(0, 1));
    s.exl   = 1'($urandom_range(0, 1));
    s.rd    = 5'($urandom_range(0, 3));
    s.redir = ($urandom_range(0, 7) == 0);
    return s;
  endfunction

  function automatic bit is_hazard(stim_t s);
    bit uses;
    uses = (s.r1e && s.r1 == s.rd) || (s.r2e && s.r2 == s.rd);
    return s.idv && s.exv && s.exl && s.rd != 0 && uses;
  endfunction

  // One clock: drive inputs, and for non-reset cycles predict the outputs.
  task automatic step(input stim_t s, input bit r);
    exp_t e;
    bit pc, ifh, ifl, bub, exh, busy;
    @(posedge clk);
    #1;
    rst         = r;
    id_valid    = s.idv;
    id_rs1_en   = s.r1e;
    id_rs2_en   = s.r2e;
    id_rs1_idx  = s.r1;
    id_rs2_idx  = s.r2;
    id_mdu      = s.mdu;
    ex_valid    = s.exv;
    ex_load     = s.exl;
    ex_rd_idx   = s.rd;
    ex_redirect = s.redir;
    if (r) begin
      mdu_end   = -1;
      flush_end = -1;
      scnt      = 0;
    end else begin
      {pc, ifh, ifl, bub, exh, busy} = '0;
      if (cyc <= mdu_end) begin
        {pc, ifh, exh, busy} = 4'hf;
      end else if (cyc <= flush_end || s.redir) begin
        {ifl, bub} = 2'b11;
        if (s.redir) flush_end = cyc + 1;
      end else if (is_hazard(s)) begin
        {pc, ifh, bub} = 3'b111;
      end else if (s.idv && s.mdu) begin
        mdu_end = cyc + MDU - 1;
      end
      e.flags = {pc, ifh, ifl, bub, exh, busy};
      e.s32   = 32'(scnt);
      e.s4    = (scnt > 15) ? 4'd15 : 4'(scnt);
      sb.push_back(e);
      if (pc) scnt++;
    end
    cyc++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [5:0] got;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = {pc_hold, ifid_hold, ifid_flush, idex_bubble, ex_hold, mdu_busy};
      checks++;
      if (got !== e.flags) begin
        errors++;
        $display("FAIL flags cyc=%0d got=%b exp=%b", cyc, got, e.flags);
      end
      checks++;
      if (stall_cnt !== e.s32) begin
        errors++;
        $display("FAIL stall32 cyc=%0d got=%0d exp=%0d",
                 cyc, stall_cnt, e.s32);
      end
      checks++;
      if (stall4 !== e.s4) begin
        errors++;
        $display("FAIL stall4 cyc=%0d got=%0d exp=%0d", cyc, stall4, e.s4);
      end
    end
  end

  initial begin
    stim_t s;
    step(rnd(), 1'b1);
    step(rnd(), 1'b1);
    step(idle(), 1'b0);
    step(idle(), 1'b0);

    s = idle();
    s.exv = 1; s.exl = 1; s.rd = 5;
    s.idv = 1; s.r2e = 1; s.r2 = 5;
    step(s, 1'b0);
    step(idle(), 1'b0);
    s.rd = 0; s.r2 = 0;
    step(s, 1'b0);
    step(idle(), 1'b0);

    s = idle();
    s.idv = 1; s.mdu = 1;
    step(s, 1'b0);
    repeat (9) step(idle(), 1'b0);

    s = idle();
    s.redir = 1;
    step(s, 1'b0);
    repeat (3) step(idle(), 1'b0);

    s = idle();
    s.exv = 1; s.exl = 1; s.rd = 7;
    s.idv = 1; s.r1e = 1; s.r1 = 7; s.redir = 1;
    step(s, 1'b0);
    repeat (3) step(idle(), 1'b0);

    s = idle();
    s.idv = 1; s.mdu = 1;
    step(s, 1'b0);
    step(idle(), 1'b0);
    s = idle();
    s.redir = 1;
    step(s, 1'b0);
    repeat (8) step(idle(), 1'b0);

    s = idle();
    s.idv = 1; s.mdu = 1;
    step(s, 1'b0);
    step(idle(), 1'b0);
    step(idle(), 1'b0);
    step(rnd(), 1'b1);
    step(idle(), 1'b0);
    step(idle(), 1'b0);

    s = idle();
    s.idv = 1; s.mdu = 1;
    repeat (3) begin
      step(s, 1'b0);
      repeat (7) step(idle(), 1'b0);
    end
    repeat (3) step(idle(), 1'b0);

    step(idle(), 1'b1);
    for (int i = 0; i < 800; i++) begin
      step(rnd(), ($urandom_range(0, 99) == 0));
    end
    step(idle(), 1'b0);

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_pipe_ctrl.md
# core_pipe_ctrl

Pipeline sequencing controller for the IF/ID/EX front end of the core. It detects load-use hazards against the decode stage and holds fetch and decode for a fixed-latency multi-cycle (MDU) operation in EX. It also flushes the IF/ID register on an EX-stage redirect and counts stall cycles. It sits beside `core_idu` and drives the hold, flush and bubble enables of the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- `RFIDX_W`, default `CPU_RFIDX_WIDTH` (5): register index width.
- `MDU_CYCLES`, default 8: EX occupancy of an MDU op in cycles; legal range 2..16.
- `CNT_W`, default 32: stall-counter width.

Ports:
- `clk`  in  1  core clock; the block uses only this clock.
- `rst`  in  1  reset, synchronous, active-high.
- `id_valid_i`  in  1  ID holds a valid instruction.
- `id_rs1_en_i`, `id_rs2_en_i`  in  1 each  ID instruction reads rs1 / rs2.
- `id_rs1_idx_i`, `id_rs2_idx_i`  in  RFIDX_W each  ID source indices.
- `id_mdu_i`  in  1  ID instruction is an MDU op.
- `ex_valid_i`  in  1  EX holds a valid instruction.
- `ex_load_i`  in  1  EX instruction is a load.
- `ex_rd_idx_i`  in  RFIDX_W  EX destination index.
- `ex_redirect_i`  in  1  EX branch/jump redirect, single-cycle pulse.
- `pc_hold_o`  out  1  freeze the PC.
- `ifid_hold_o`  out  1  freeze the IF/ID register.
- `ifid_flush_o`  out  1  invalidate the IF/ID register.
- `idex_bubble_o`  out  1  load a bubble into ID/EX.
- `ex_hold_o`  out  1  freeze the ID/EX register and EX.
- `mdu_busy_o`  out  1  state is MDU_WAIT.
- `stall_cnt_o`  out  CNT_W  saturating count of cycles with `pc_hold_o` = 1.

## Operation
- States: RUN, MDU_WAIT, FLUSH. Reset: state = RUN, MDU counter = 0, `stall_cnt_o` = 0.
- `hazard` = `id_valid_i` & `ex_valid_i` & `ex_load_i` & (`ex_rd_idx_i` != 0) & ((`id_rs1_en_i` & rs1 == rd) | (`id_rs2_en_i` & rs2 == rd)).
- RUN, evaluated in priority order:
  - `ex_redirect_i` = 1: `ifid_flush_o` = 1 and `idex_bubble_o` = 1; all holds = 0. Next state FLUSH.
  - else `hazard` = 1: `pc_hold_o`, `ifid_hold_o` and `idex_bubble_o` = 1. Stay in RUN. The hazard clears once the load leaves EX, so the stall lasts exactly 1 cycle.
  - else `id_valid_i` & `id_mdu_i`: the op issues normally (all outputs 0). Next state MDU_WAIT with counter = MDU_CYCLES−2.
  - else: all outputs 0.
- MDU_WAIT:
  - `pc_hold_o`, `ifid_hold_o`, `ex_hold_o` and `mdu_busy_o` = 1; `idex_bubble_o` = 0.
  - Counter decrements each cycle. When the counter is 0, next state is RUN.
  - `ex_redirect_i` and `hazard` are ignored in this state; EX holds the MDU op, so neither can be legitimate.
- FLUSH: `ifid_flush_o` = 1 and `idex_bubble_o` = 1 for one cycle to kill the in-flight wrong-path fetch. Next state RUN.
  - A new `ex_redirect_i` in FLUSH restarts FLUSH for one more cycle.
- `stall_cnt_o` increments every cycle with `pc_hold_o` = 1 and saturates at all-ones; it never wraps.
- `rst` asserted in any state forces the reset values on the next edge. An MDU op in progress is abandoned; the datapath is reset in the same cycle.

## Timing
- All `_o` except `stall_cnt_o` and `mdu_busy_o` are Mealy, combinational from the current state and inputs. They are valid in the same cycle as the inputs, so a hazard stall acts with zero latency.
- `mdu_busy_o` and `stall_cnt_o` are registered.
- An MDU op issued in cycle T occupies EX for cycles T+1..T+MDU_CYCLES−1 with `ex_hold_o` = 1. The block is in RUN again at T+MDU_CYCLES, so total EX residency is MDU_CYCLES cycles.
- A redirect in cycle T asserts `ifid_flush_o` in T and T+1; fetch proceeds from T+2.
- A redirect and a hazard in the same RUN cycle: the redirect wins and there is no stall.
- `stall_cnt_o` reflects `pc_hold_o` of cycle T at T+1.

## Structure
- Add to `core_defines.v`: state encodings `CPU_PCTL_RUN` = 2'd0, `CPU_PCTL_MDU` = 2'd1, `CPU_PCTL_FLUSH` = 2'd2, and `CPU_MDU_CYCLES`.
- One sub-module, `core_hazard_det`: purely combinational `hazard` compare, reusable by the forwarding logic.
- The top level holds the FSM, the MDU down-counter ($clog2(MDU_CYCLES) bits) and the stall counter.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with random inputs. Afterwards all outputs = 0 with inputs idle, state = RUN, `stall_cnt_o` = 0.
- Load-use: EX load with rd = 5, ID reads rs2 = 5 → exactly one cycle of `pc_hold_o`, `ifid_hold_o` and `idex_bubble_o`; `stall_cnt_o` = 1. Repeat with rd = 0 → no stall.
- MDU with MDU_CYCLES = 8, issue at T → `ex_hold_o` = 1 in T+1..T+7, `mdu_busy_o` = 1 in T+1..T+7, RUN at T+8, `stall_cnt_o` = 7.
- Redirect at T → `ifid_flush_o` = 1 in T and T+1, and 0 at T+2. Redirect plus hazard in the same cycle → flush only, no hold.
- Redirect pulse during MDU_WAIT → ignored: no flush, and the hold continues to term.
- `rst` asserted at T+3 of an MDU op → state RUN and outputs 0 at T+4. Preload CNT_W = 4 and stall 20 cycles → `stall_cnt_o` = 15 and holds there.
